// File: rtl/chan_select_reg.sv
// Registered N-to-1 channel selector with manual select, auto-scan and hold.
// All outputs come straight from flops; reset is synchronous and active-high.
module chan_select_reg #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int DWELL = 4,
  localparam int SW   = (N > 1) ? $clog2(N) : 1,
  localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in,
  input  logic [SW-1:0]      select,
  input  logic               auto,
  input  logic               hold,
  output logic [WIDTH-1:0]   out,
  output logic [SW-1:0]      chan,
  output logic               valid
);

  localparam logic [0:0] MANUAL = 1'b0;
  localparam logic [0:0] SCAN   = 1'b1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [SW-1:0] CHAN_LAST = SW'(N - 1);

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ch [N];

  logic             sel_legal;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] cur_data;
  logic [SW-1:0]    nxt_chan;
  logic [WIDTH-1:0] nxt_data;

  for (genvar k = 0; k < N; k++) begin : g_split
    assign ch[k] = in[k*WIDTH +: WIDTH];
  end

  // Explicit compare-and-pick muxes keep out-of-range indices harmless
  // when N is not a power of two.
  always_comb begin
    sel_legal = 1'b0;
    sel_data  = '0;
    cur_data  = '0;
    nxt_data  = '0;
    nxt_chan  = (chan == CHAN_LAST) ? '0 : chan + SW'(1);
    for (int k = 0; k < N; k++) begin
      if (select == SW'(k)) begin
        sel_legal = 1'b1;
        sel_data  = ch[k];
      end
      if (chan == SW'(k)) begin
        cur_data = ch[k];
      end
      if (nxt_chan == SW'(k)) begin
        nxt_data = ch[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MANUAL;
      cnt   <= '0;
      out   <= '0;
      chan  <= '0;
      valid <= 1'b0;
    end else if (!hold) begin
      if (!auto) begin
        state <= MANUAL;
        cnt   <= '0;
        if (sel_legal) begin
          out   <= sel_data;
          chan  <= select;
          valid <= 1'b1;
        end else begin
          valid <= 1'b0;
        end
      end else if (state == MANUAL) begin
        // Scan always restarts from channel 0; the entry edge is the first dwell edge.
        state <= SCAN;
        cnt   <= '0;
        out   <= ch[0];
        chan  <= '0;
        valid <= 1'b1;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        out   <= nxt_data;
        chan  <= nxt_chan;
        valid <= 1'b1;
      end else begin
        cnt   <= cnt + CW'(1);
        out   <= cur_data;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chan_select_reg.sv
// Randomized scoreboard bench for chan_select_reg (N=3 to exercise illegal selects).
// Expected values come from a position-based scan model, pushed on drive and popped by a monitor.
module tb_chan_select_reg;

  localparam int WIDTH = 8;
  localparam int N     = 3;
  localparam int DWELL = 3;
  localparam int SW    = 2;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic [SW-1:0]    chan;
    logic             valid;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic [N*WIDTH-1:0] in;
  logic [SW-1:0]      select;
  logic               auto;
  logic               hold;
  logic [WIDTH-1:0]   out;
  logic [SW-1:0]      chan;
  logic               valid;

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];

  // Reference state: mode, elapsed scan edges since entry, and visible outputs.
  bit          m_scan;
  int          m_pos;
  int          m_out;
  int          m_chan;
  bit          m_valid;
  logic [7:0]  chans [N];

  chan_select_reg #(.WIDTH(WIDTH), .N(N), .DWELL(DWELL)) dut (
    .clk(clk), .reset(reset), .in(in), .select(select), .auto(auto),
    .hold(hold), .out(out), .chan(chan), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_output("out",   int'(out),   int'(e.out));
      check_output("chan",  int'(chan),  int'(e.chan));
      check_output("valid", int'(valid), int'(e.valid));
    end
  end

  // Drive one cycle of inputs at the falling edge and predict the next registered outputs.
  task automatic apply_stimulus(input bit r, input bit h, input bit a, input int sel);
    exp_t e;
    reset  = r;
    hold   = h;
    auto   = a;
    select = SW'(sel);
    for (int k = 0; k < N; k++) chans[k] = in[k*WIDTH +: WIDTH];
    if (r) begin
      m_scan = 0; m_pos = 0; m_out = 0; m_chan = 0; m_valid = 0;
    end else if (h) begin
      // frozen
    end else if (a && !m_scan) begin
      m_scan = 1; m_pos = 0; m_chan = 0; m_out = chans[0]; m_valid = 1;
    end else if (a) begin
      m_pos   = m_pos + 1;
      m_chan  = (m_pos / DWELL) % N;
      m_out   = chans[m_chan];
      m_valid = 1;
    end else begin
      m_scan = 0;
      if (sel < N) begin
        m_out = chans[sel]; m_chan = sel; m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
    e.out   = WIDTH'(m_out);
    e.chan  = SW'(m_chan);
    e.valid = m_valid;
    exp_q.push_back(e);
  endtask

  task automatic rand_inputs();
    if ($urandom_range(0, 1) == 0) begin
      in = {$urandom, $urandom};
    end else begin
      int k;
      k = $urandom_range(0, N - 1);
      in[k*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
  endtask

  initial begin
    bit a;
    reset = 1'b1; hold = 1'b1; auto = 1'b1; select = '0; in = '0;
    m_scan = 0; m_pos = 0; m_out = 0; m_chan = 0; m_valid = 0;

    // Reset overrides hold and auto.
    @(negedge clk);
    apply_stimulus(1, 1, 1, 0);
    @(negedge clk);
    apply_stimulus(1, 1, 1, 0);

    // Manual stepping then an illegal select.
    in = {8'h33, 8'h22, 8'h11};
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      apply_stimulus(0, 0, 0, s);
    end
    @(negedge clk);
    apply_stimulus(0, 0, 0, 0);

    // Two full uninterrupted scan rounds with live data changes.
    for (int i = 0; i < 2 * N * DWELL + 1; i++) begin
      @(negedge clk);
      if (i == 4) in[WIDTH +: WIDTH] = 8'h99;
      apply_stimulus(0, 0, 1, 0);
    end

    // Randomized mix of reset, hold, mode toggles and selects.
    a = 1'b1;
    for (int i = 0; i < 800; i++) begin
      int r;
      @(negedge clk);
      rand_inputs();
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 99) < 8) a = ~a;
      apply_stimulus(r < 3, (r >= 3) && (r < 18), a, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
